key_expand_ctrl: RTL

- Iterative AES-128 key-schedule sequencer.
- Instantiates one round-key generation datapath and drives it for 10 consecutive cycles. The datapath does RotWord, four S-box lookups, an XOR with a selectable rcon, and the w0..w3 XOR chain.
- Each cycle it selects the rcon for the current round and stores every resulting round key in an 11-entry key buffer.
- The cipher round sequencer reads round keys from this buffer by index, so per-round gen_key instances are no longer needed.

---
 rtl/key_expand_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one round-key datapath reused for 10 cycles,
// with all 11 round keys held in a buffer that the cipher reads by index.
module key_expand_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_round,
  output logic [0:127] rd_key
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  // Index 0 is the most significant byte of the packed constant.
  localparam logic [0:255][7:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state;
  logic [3:0]   round;
  logic [127:0] work;
  logic [127:0] key_buf [NUM_ROUNDS+1];

  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
  logic [127:0] next_key;

  always_comb begin
    unique case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Round-key datapath: SubWord(RotWord(w3)) ^ rcon, then the w0..w3 XOR chain.
  always_comb begin
    w0       = work[127:96];
    w1       = work[95:64];
    w2       = work[63:32];
    w3       = work[31:0];
    rot      = {w3[23:0], w3[31:24]};
    sub      = {Sbox[rot[31:24]], Sbox[rot[23:16]], Sbox[rot[15:8]], Sbox[rot[7:0]]};
    temp     = sub ^ {rcon, 24'h000000};
    n0       = w0 ^ temp;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      round     <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      work      <= '0;
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) key_buf[i] <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            key_buf[0] <= key_in;
            work       <= key_in;
            round      <= 4'd1;
            key_valid  <= 1'b0;
            busy       <= 1'b1;
            state      <= StExpand;
          end
        end
        StExpand: begin
          key_buf[round] <= next_key;
          work           <= next_key;
          if (round == LastRound) begin
            round     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
            state     <= StDone;
          end else begin
            round <= round + 4'd1;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_round <= LastRound) rd_key = key_buf[rd_round];
  end

endmodule
